c7bbiu_rd_sched: RTL and testbench

Read-side scheduler for the BIU. Arbitrates instruction-fetch (IFU) and load (LSU) read requests onto the single AXI read address channel. Tracks the one outstanding read and routes returning R beats to their owner. Handles IFU cancel by dropping the cancelled fetch's data, and bounds IFU starvation with a grant-streak counter.

---
 rtl/c7bbiu_rd_sched_if.sv | 68 ++++++
 rtl/c7bbiu_rd_sched.sv | 146 ++++++++++++++
 tb/tb_c7bbiu_rd_sched.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/c7bbiu_rd_sched_if.sv
// Read-side BIU bundle: IFU and LSU request/response links plus the AXI AR/R channels.
// Optional fault outputs exist only when C7BBIU_RD_FAULT_EN is defined.
interface c7bbiu_rd_sched_if;
  // IFU link
  logic        ifu_biu_rd_req;
  logic [31:0] ifu_biu_rd_addr;
  logic        ifu_biu_cancel;
  logic        biu_ifu_rd_ack;
  logic        biu_ifu_data_valid;
  logic [31:0] biu_ifu_data;
  // LSU link
  logic        lsu_biu_rd_req;
  logic [31:0] lsu_biu_rd_addr;
  logic        biu_lsu_rd_ack;
  logic        biu_lsu_data_valid;
  logic [31:0] biu_lsu_data;
  // AXI read address channel
  logic        ext_biu_ar_ready;
  logic        biu_ext_ar_valid;
  logic [3:0]  biu_ext_ar_id;
  logic [31:0] biu_ext_ar_addr;
  logic [7:0]  biu_ext_ar_len;
  logic [2:0]  biu_ext_ar_size;
  logic [1:0]  biu_ext_ar_burst;
  // AXI read data channel
  logic        biu_ext_r_ready;
  logic        ext_biu_r_valid;
  logic [3:0]  ext_biu_r_id;
  logic [31:0] ext_biu_r_data;
  logic        ext_biu_r_last;
  logic [1:0]  ext_biu_r_resp;
`ifdef C7BBIU_RD_FAULT_EN
  logic        biu_ifu_fault;
  logic        biu_lsu_fault;
`endif

  // Scheduler side
  modport slave (
`ifdef C7BBIU_RD_FAULT_EN
    output biu_ifu_fault, biu_lsu_fault,
`endif
    input  ifu_biu_rd_req, ifu_biu_rd_addr, ifu_biu_cancel,
    output biu_ifu_rd_ack, biu_ifu_data_valid, biu_ifu_data,
    input  lsu_biu_rd_req, lsu_biu_rd_addr,
    output biu_lsu_rd_ack, biu_lsu_data_valid, biu_lsu_data,
    input  ext_biu_ar_ready,
    output biu_ext_ar_valid, biu_ext_ar_id, biu_ext_ar_addr,
    output biu_ext_ar_len, biu_ext_ar_size, biu_ext_ar_burst,
    output biu_ext_r_ready,
    input  ext_biu_r_valid, ext_biu_r_id, ext_biu_r_data, ext_biu_r_last, ext_biu_r_resp
  );

  // Environment side: requesters and the AXI slave
  modport master (
`ifdef C7BBIU_RD_FAULT_EN
    input  biu_ifu_fault, biu_lsu_fault,
`endif
    output ifu_biu_rd_req, ifu_biu_rd_addr, ifu_biu_cancel,
    input  biu_ifu_rd_ack, biu_ifu_data_valid, biu_ifu_data,
    output lsu_biu_rd_req, lsu_biu_rd_addr,
    input  biu_lsu_rd_ack, biu_lsu_data_valid, biu_lsu_data,
    output ext_biu_ar_ready,
    input  biu_ext_ar_valid, biu_ext_ar_id, biu_ext_ar_addr,
    input  biu_ext_ar_len, biu_ext_ar_size, biu_ext_ar_burst,
    input  biu_ext_r_ready,
    output ext_biu_r_valid, ext_biu_r_id, ext_biu_r_data, ext_biu_r_last, ext_biu_r_resp
  );
endinterface

// File: rtl/c7bbiu_rd_sched.sv
// BIU read scheduler: arbitrates IFU/LSU reads onto one AXI AR channel, one read in flight.
// Define C7BBIU_RD_FAULT_EN to add per-requester fault outputs driven from R resp[1].
module c7bbiu_rd_sched #(
  parameter int       STARVE_MAX = 4,
  parameter bit [3:0] IFU_ID     = 4'h0,
  parameter bit [3:0] LSU_ID     = 4'h1
) (
  input  logic              clk,
  input  logic              resetn,
  c7bbiu_rd_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_AR    = 2'd1,
    ST_RDATA = 2'd2
  } state_t;

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);
  localparam int         OWN_IFU    = 0;

  state_t      state_reg, state_next;
  logic        owner_reg, owner_next;     // 0 = IFU, 1 = LSU
  logic [31:0] addr_reg, addr_next;
  logic [3:0]  id_reg, id_next;
  logic [2:0]  streak_reg, streak_next;
  logic        drop_reg, drop_next;

  logic        any_req;
  logic        grant_lsu;
  logic        ar_hs;
  logic        beat_match;
  logic        cancel_hit;
  logic [1:0]  suppress_vec;
  logic [1:0]  ack_vec;
  logic [1:0]  valid_vec;

  assign any_req   = bus.ifu_biu_rd_req | bus.lsu_biu_rd_req;
  // LSU wins ties until IFU has been passed over STARVE_MAX times in a row
  assign grant_lsu = bus.lsu_biu_rd_req &
                     ~(bus.ifu_biu_rd_req & (streak_reg == STARVE_LIM));

  assign ar_hs      = (state_reg == ST_AR) & bus.ext_biu_ar_ready;
  assign beat_match = (state_reg == ST_RDATA) & bus.ext_biu_r_valid &
                      (bus.ext_biu_r_id == id_reg);
  assign cancel_hit = bus.ifu_biu_cancel & (owner_reg == 1'(OWN_IFU));

  // A cancel in the beat's own cycle must already hide that beat
  assign suppress_vec = {1'b0, drop_reg | bus.ifu_biu_cancel};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign ack_vec[gi]   = ar_hs & (owner_reg == 1'(gi));
      assign valid_vec[gi] = beat_match & (owner_reg == 1'(gi)) & ~suppress_vec[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg  <= ST_IDLE;
      owner_reg  <= 1'(OWN_IFU);
      addr_reg   <= 32'd0;
      id_reg     <= IFU_ID;
      streak_reg <= 3'd0;
      drop_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      owner_reg  <= owner_next;
      addr_reg   <= addr_next;
      id_reg     <= id_next;
      streak_reg <= streak_next;
      drop_reg   <= drop_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    owner_next  = owner_reg;
    addr_next   = addr_reg;
    id_next     = id_reg;
    streak_next = streak_reg;
    drop_next   = drop_reg;
    case (state_reg)
      ST_IDLE: begin
        drop_next = 1'b0;
        if (any_req) begin
          owner_next = grant_lsu;
          addr_next  = grant_lsu ? bus.lsu_biu_rd_addr : bus.ifu_biu_rd_addr;
          id_next    = grant_lsu ? LSU_ID : IFU_ID;
          state_next = ST_AR;
          if (!grant_lsu) begin
            streak_next = 3'd0;
          end else if (bus.ifu_biu_rd_req && (streak_reg != 3'd7)) begin
            streak_next = streak_reg + 3'd1;
          end
        end
      end
      ST_AR: begin
        if (cancel_hit) begin
          drop_next = 1'b1;
        end
        if (bus.ext_biu_ar_ready) begin
          state_next = ST_RDATA;
        end
      end
      ST_RDATA: begin
        if (cancel_hit) begin
          drop_next = 1'b1;
        end
        if (beat_match && bus.ext_biu_r_last) begin
          state_next = ST_IDLE;
          drop_next  = 1'b0;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.biu_ext_ar_valid  = (state_reg == ST_AR);
  assign bus.biu_ext_ar_id     = id_reg;
  assign bus.biu_ext_ar_addr   = addr_reg;
  assign bus.biu_ext_ar_len    = 8'd0;
  assign bus.biu_ext_ar_size   = 3'b010;
  assign bus.biu_ext_ar_burst  = 2'b01;
  // Mismatched-id beats are still accepted so a stray response cannot stall R
  assign bus.biu_ext_r_ready   = (state_reg == ST_RDATA);

  assign bus.biu_ifu_rd_ack     = ack_vec[0];
  assign bus.biu_lsu_rd_ack     = ack_vec[1];
  assign bus.biu_ifu_data_valid = valid_vec[0];
  assign bus.biu_lsu_data_valid = valid_vec[1];
  assign bus.biu_ifu_data       = bus.ext_biu_r_data;
  assign bus.biu_lsu_data       = bus.ext_biu_r_data;

`ifdef C7BBIU_RD_FAULT_EN
  assign bus.biu_ifu_fault = valid_vec[0] & bus.ext_biu_r_resp[1];
  assign bus.biu_lsu_fault = valid_vec[1] & bus.ext_biu_r_resp[1];
`else
  logic unused_resp;
  assign unused_resp = ^bus.ext_biu_r_resp;
`endif

endmodule

// File: tb/tb_c7bbiu_rd_sched.sv
// Directed bench for c7bbiu_rd_sched: grant order, AR stall, cancel, stray beats, mid-read reset.
// Fault outputs are checked when C7BBIU_RD_FAULT_EN is defined.
module tb_c7bbiu_rd_sched;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  c7bbiu_rd_sched_if bus();

  c7bbiu_rd_sched #(
    .STARVE_MAX (4),
    .IFU_ID     (4'h0),
    .LSU_ID     (4'h1)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  // Expected grant order with both requesters always pending: bit k = 1 means LSU
  logic [9:0] exp_lsu_order = 10'b0111101111;

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic beat(input logic [3:0] id, input logic [31:0] data,
                      input logic last, input logic [1:0] resp);
    bus.ext_biu_r_valid = 1'b1;
    bus.ext_biu_r_id    = id;
    bus.ext_biu_r_data  = data;
    bus.ext_biu_r_last  = last;
    bus.ext_biu_r_resp  = resp;
  endtask

  initial begin
    logic       is_lsu;
    logic [3:0] exp_id;

    resetn                = 1'b0;
    bus.ifu_biu_rd_req    = 1'b0;
    bus.ifu_biu_rd_addr   = 32'd0;
    bus.ifu_biu_cancel    = 1'b0;
    bus.lsu_biu_rd_req    = 1'b0;
    bus.lsu_biu_rd_addr   = 32'd0;
    bus.ext_biu_ar_ready  = 1'b0;
    bus.ext_biu_r_valid   = 1'b0;
    bus.ext_biu_r_id      = 4'h0;
    bus.ext_biu_r_data    = 32'd0;
    bus.ext_biu_r_last    = 1'b0;
    bus.ext_biu_r_resp    = 2'b00;

    // Reset state
    tick(); #1;
    chkb("rst_ar_valid", bus.biu_ext_ar_valid, 1'b0);
    chkb("rst_r_ready", bus.biu_ext_r_ready, 1'b0);
    chkb("rst_ifu_ack", bus.biu_ifu_rd_ack, 1'b0);
    chkb("rst_lsu_ack", bus.biu_lsu_rd_ack, 1'b0);
    chkb("rst_ifu_valid", bus.biu_ifu_data_valid, 1'b0);
    chkb("rst_lsu_valid", bus.biu_lsu_data_valid, 1'b0);
    chkw("rst_ar_addr", bus.biu_ext_ar_addr, 32'd0);
    chkw("rst_ar_id", 32'(bus.biu_ext_ar_id), 32'h0);
    chkw("rst_ar_len", 32'(bus.biu_ext_ar_len), 32'd0);
    chkw("rst_ar_size", 32'(bus.biu_ext_ar_size), 32'd2);
    chkw("rst_ar_burst", 32'(bus.biu_ext_ar_burst), 32'd1);
`ifdef C7BBIU_RD_FAULT_EN
    chkb("rst_ifu_fault", bus.biu_ifu_fault, 1'b0);
    chkb("rst_lsu_fault", bus.biu_lsu_fault, 1'b0);
`endif
    tick(); resetn = 1'b1;

    // Single IFU read, minimum latency
    tick(); bus.ifu_biu_rd_req = 1'b1; bus.ifu_biu_rd_addr = 32'h1C00_0000;
    bus.ext_biu_ar_ready = 1'b1; #1;
    chkb("t1_c0_ar_valid", bus.biu_ext_ar_valid, 1'b0);
    chkb("t1_c0_ifu_ack", bus.biu_ifu_rd_ack, 1'b0);
    tick(); #1;
    chkb("t1_c1_ar_valid", bus.biu_ext_ar_valid, 1'b1);
    chkw("t1_c1_ar_addr", bus.biu_ext_ar_addr, 32'h1C00_0000);
    chkw("t1_c1_ar_id", 32'(bus.biu_ext_ar_id), 32'h0);
    chkb("t1_c1_ifu_ack", bus.biu_ifu_rd_ack, 1'b1);
    chkb("t1_c1_lsu_ack", bus.biu_lsu_rd_ack, 1'b0);
    tick(); bus.ifu_biu_rd_req = 1'b0; beat(4'h0, 32'hDEAD_BEEF, 1'b1, 2'b00); #1;
    chkb("t1_c2_r_ready", bus.biu_ext_r_ready, 1'b1);
    chkb("t1_c2_ifu_valid", bus.biu_ifu_data_valid, 1'b1);
    chkw("t1_c2_ifu_data", bus.biu_ifu_data, 32'hDEAD_BEEF);
    chkb("t1_c2_lsu_valid", bus.biu_lsu_data_valid, 1'b0);
`ifdef C7BBIU_RD_FAULT_EN
    chkb("t1_c2_ifu_fault", bus.biu_ifu_fault, 1'b0);
`endif
    $display("txn ifu addr=1c000000 data=%h", bus.biu_ifu_data);
    tick(); bus.ext_biu_r_valid = 1'b0; #1;
    chkb("t1_c3_r_ready", bus.biu_ext_r_ready, 1'b0);
    chkb("t1_c3_ar_valid", bus.biu_ext_ar_valid, 1'b0);

    // Tie goes to LSU; AR held stable while ar_ready is low
    tick(); bus.ifu_biu_rd_req = 1'b1; bus.ifu_biu_rd_addr = 32'h1C00_0040;
    bus.lsu_biu_rd_req = 1'b1; bus.lsu_biu_rd_addr = 32'h8000_1000;
    bus.ext_biu_ar_ready = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chkb("t2_stall_ar_valid", bus.biu_ext_ar_valid, 1'b1);
      chkw("t2_stall_ar_id", 32'(bus.biu_ext_ar_id), 32'h1);
      chkw("t2_stall_ar_addr", bus.biu_ext_ar_addr, 32'h8000_1000);
      chkb("t2_stall_lsu_ack", bus.biu_lsu_rd_ack, 1'b0);
      chkb("t2_stall_ifu_ack", bus.biu_ifu_rd_ack, 1'b0);
    end
    tick(); bus.ext_biu_ar_ready = 1'b1; #1;
    chkb("t2_hs_lsu_ack", bus.biu_lsu_rd_ack, 1'b1);
    chkb("t2_hs_ifu_ack", bus.biu_ifu_rd_ack, 1'b0);
    tick(); bus.lsu_biu_rd_req = 1'b0; beat(4'h1, 32'hCAFE_0001, 1'b1, 2'b00); #1;
    chkb("t2_lsu_valid", bus.biu_lsu_data_valid, 1'b1);
    chkw("t2_lsu_data", bus.biu_lsu_data, 32'hCAFE_0001);
    chkb("t2_ifu_valid", bus.biu_ifu_data_valid, 1'b0);
    $display("txn lsu addr=80001000 data=%h", bus.biu_lsu_data);
    tick(); bus.ext_biu_r_valid = 1'b0; #1;
    tick(); #1;
    chkw("t2_ifu_ar_addr", bus.biu_ext_ar_addr, 32'h1C00_0040);
    chkb("t2_ifu_ack", bus.biu_ifu_rd_ack, 1'b1);
    tick(); bus.ifu_biu_rd_req = 1'b0; beat(4'h0, 32'h1111_2222, 1'b1, 2'b00); #1;
    chkb("t2_ifu_valid2", bus.biu_ifu_data_valid, 1'b1);
    $display("txn ifu addr=1c000040 data=%h", bus.biu_ifu_data);
    tick(); bus.ext_biu_r_valid = 1'b0; #1;

    // Starvation bound: LSU x4 then IFU, repeating
    tick(); bus.ifu_biu_rd_req = 1'b1; bus.ifu_biu_rd_addr = 32'h1C00_0200;
    bus.lsu_biu_rd_req = 1'b1; bus.lsu_biu_rd_addr = 32'h8000_5000; #1;
    for (int k = 0; k < 10; k++) begin
      is_lsu = exp_lsu_order[k];
      exp_id = is_lsu ? 4'h1 : 4'h0;
      tick(); #1;
      chkw("t3_ar_id", 32'(bus.biu_ext_ar_id), 32'(exp_id));
      chkw("t3_ar_addr", bus.biu_ext_ar_addr, is_lsu ? 32'h8000_5000 : 32'h1C00_0200);
      chkb("t3_lsu_ack", bus.biu_lsu_rd_ack, is_lsu);
      chkb("t3_ifu_ack", bus.biu_ifu_rd_ack, ~is_lsu);
      tick(); beat(exp_id, 32'hA000_0000 + 32'(k), 1'b1, 2'b00); #1;
      chkb("t3_lsu_valid", bus.biu_lsu_data_valid, is_lsu);
      chkb("t3_ifu_valid", bus.biu_ifu_data_valid, ~is_lsu);
      $display("txn grant %0d owner=%s data=%h", k, is_lsu ? "lsu" : "ifu",
               bus.ext_biu_r_data);
      tick(); bus.ext_biu_r_valid = 1'b0;
      if (k == 9) begin
        bus.ifu_biu_rd_req = 1'b0;
        bus.lsu_biu_rd_req = 1'b0;
      end
      #1;
    end

    // Cancel pulse before the beat drops the data; FSM still completes
    tick(); bus.ifu_biu_rd_req = 1'b1; bus.ifu_biu_rd_addr = 32'h1C00_0080; #1;
    tick(); #1;
    chkb("t4a_ifu_ack", bus.biu_ifu_rd_ack, 1'b1);
    tick(); bus.ifu_biu_rd_req = 1'b0; bus.ifu_biu_cancel = 1'b1; #1;
    tick(); bus.ifu_biu_cancel = 1'b0; beat(4'h0, 32'h0BAD_F00D, 1'b1, 2'b00); #1;
    chkb("t4a_r_ready", bus.biu_ext_r_ready, 1'b1);
    chkb("t4a_dropped_valid", bus.biu_ifu_data_valid, 1'b0);
    $display("txn ifu addr=1c000080 cancelled");
    tick(); bus.ext_biu_r_valid = 1'b0; #1;
    chkb("t4a_idle_r_ready", bus.biu_ext_r_ready, 1'b0);

    // Cancel in the same cycle as the beat
    tick(); bus.ifu_biu_rd_req = 1'b1; bus.ifu_biu_rd_addr = 32'h1C00_00C0; #1;
    tick(); #1;
    chkb("t4b_ifu_ack", bus.biu_ifu_rd_ack, 1'b1);
    tick(); bus.ifu_biu_rd_req = 1'b0; bus.ifu_biu_cancel = 1'b1;
    beat(4'h0, 32'h55AA_55AA, 1'b1, 2'b10); #1;
    chkb("t4b_same_cycle_valid", bus.biu_ifu_data_valid, 1'b0);
`ifdef C7BBIU_RD_FAULT_EN
    chkb("t4b_dropped_fault", bus.biu_ifu_fault, 1'b0);
`endif
    $display("txn ifu addr=1c0000c0 cancelled with beat");
    tick(); bus.ifu_biu_cancel = 1'b0; bus.ext_biu_r_valid = 1'b0; #1;
    chkb("t4b_idle_r_ready", bus.biu_ext_r_ready, 1'b0);

    // Next IFU read after cancel delivers normally
    tick(); bus.ifu_biu_rd_req = 1'b1; bus.ifu_biu_rd_addr = 32'h1C00_0100; #1;
    tick(); #1;
    chkb("t4c_ifu_ack", bus.biu_ifu_rd_ack, 1'b1);
    tick(); bus.ifu_biu_rd_req = 1'b0; beat(4'h0, 32'h600D_DA7A, 1'b1, 2'b00); #1;
    chkb("t4c_ifu_valid", bus.biu_ifu_data_valid, 1'b1);
    chkw("t4c_ifu_data", bus.biu_ifu_data, 32'h600D_DA7A);
    $display("txn ifu addr=1c000100 data=%h", bus.biu_ifu_data);
    tick(); bus.ext_biu_r_valid = 1'b0; #1;

    // Stray beat with the wrong id is swallowed
    tick(); bus.lsu_biu_rd_req = 1'b1; bus.lsu_biu_rd_addr = 32'h8000_2000; #1;
    tick(); #1;
    chkb("t5_lsu_ack", bus.biu_lsu_rd_ack, 1'b1);
    chkw("t5_ar_id", 32'(bus.biu_ext_ar_id), 32'h1);
    tick(); bus.lsu_biu_rd_req = 1'b0; beat(4'h0, 32'hBAD0_BAD0, 1'b1, 2'b00); #1;
    chkb("t5_stray_r_ready", bus.biu_ext_r_ready, 1'b1);
    chkb("t5_stray_lsu_valid", bus.biu_lsu_data_valid, 1'b0);
    chkb("t5_stray_ifu_valid", bus.biu_ifu_data_valid, 1'b0);
    chkw("t5_stray_passthru", bus.biu_ifu_data, 32'hBAD0_BAD0);
    tick(); beat(4'h1, 32'h1234_5678, 1'b1, 2'b00); #1;
    chkb("t5_lsu_valid", bus.biu_lsu_data_valid, 1'b1);
    chkw("t5_lsu_data", bus.biu_lsu_data, 32'h1234_5678);
    $display("txn lsu addr=80002000 data=%h", bus.biu_lsu_data);
    tick(); bus.ext_biu_r_valid = 1'b0; #1;
    chkb("t5_idle_r_ready", bus.biu_ext_r_ready, 1'b0);

    // Reset mid-read, then a clean LSU read
    tick(); bus.lsu_biu_rd_req = 1'b1; bus.lsu_biu_rd_addr = 32'h8000_3000; #1;
    tick(); #1;
    chkb("t6_lsu_ack", bus.biu_lsu_rd_ack, 1'b1);
    tick(); bus.lsu_biu_rd_req = 1'b0; beat(4'h1, 32'h7777_7777, 1'b0, 2'b00); #1;
    chkb("t6_first_beat_valid", bus.biu_lsu_data_valid, 1'b1);
    tick(); resetn = 1'b0; beat(4'h1, 32'h8888_8888, 1'b1, 2'b00); #1;
    chkb("t6_rst_r_ready", bus.biu_ext_r_ready, 1'b0);
    chkb("t6_rst_lsu_valid", bus.biu_lsu_data_valid, 1'b0);
    chkb("t6_rst_ar_valid", bus.biu_ext_ar_valid, 1'b0);
    chkw("t6_rst_ar_addr", bus.biu_ext_ar_addr, 32'd0);
    chkw("t6_rst_ar_id", 32'(bus.biu_ext_ar_id), 32'h0);
    $display("txn lsu addr=80003000 abandoned by reset");
    tick(); resetn = 1'b1; bus.ext_biu_r_valid = 1'b0; #1;
    chkb("t6_post_rst_r_ready", bus.biu_ext_r_ready, 1'b0);
    tick(); bus.lsu_biu_rd_req = 1'b1; bus.lsu_biu_rd_addr = 32'h8000_4000; #1;
    tick(); #1;
    chkb("t6b_lsu_ack", bus.biu_lsu_rd_ack, 1'b1);
    chkw("t6b_ar_addr", bus.biu_ext_ar_addr, 32'h8000_4000);
    tick(); bus.lsu_biu_rd_req = 1'b0; beat(4'h1, 32'h9999_AAAA, 1'b1, 2'b10); #1;
    chkb("t6b_lsu_valid", bus.biu_lsu_data_valid, 1'b1);
    chkw("t6b_lsu_data", bus.biu_lsu_data, 32'h9999_AAAA);
`ifdef C7BBIU_RD_FAULT_EN
    chkb("t6b_lsu_fault", bus.biu_lsu_fault, 1'b1);
    chkb("t6b_ifu_fault", bus.biu_ifu_fault, 1'b0);
`endif
    $display("txn lsu addr=80004000 data=%h", bus.biu_lsu_data);
    tick(); bus.ext_biu_r_valid = 1'b0; #1;
    chkb("t6b_idle_r_ready", bus.biu_ext_r_ready, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
